// File: rtl/rf_fifo_ctrl_if.sv
// Enqueue/dequeue handshake bundle between the FIFO controller and its producer/consumer.
interface rf_fifo_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/rf_fifo_ctrl.sv
// Circular FIFO controller on top of a 32-entry register file, with a slow
// display scanner walking the occupied slots through the second read port.
module rf_fifo_ctrl #(
    parameter int WIDTH         = 32,
    parameter int REGFILE_WIDTH = 5,
    parameter int SCAN_DIV      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    rf_fifo_ctrl_if.slave            bus,
    output logic [REGFILE_WIDTH-1:0] rf_ra0,
    input  logic [WIDTH-1:0]         rf_rd0,
    output logic [REGFILE_WIDTH-1:0] rf_ra1,
    input  logic [WIDTH-1:0]         rf_rd1,
    output logic [REGFILE_WIDTH-1:0] rf_wa,
    output logic                     rf_we,
    output logic [WIDTH-1:0]         rf_wd,
    output logic [REGFILE_WIDTH:0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [REGFILE_WIDTH-1:0] scan_idx,
    output logic [WIDTH-1:0]         scan_data,
    output logic                     scan_valid
);
    localparam int CW    = REGFILE_WIDTH + 1;
    localparam int DEPTH = 2 ** REGFILE_WIDTH;
    localparam int DIVW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   COUNT_FULL = CW'(DEPTH);
    localparam logic [DIVW-1:0] DIV_LAST   = DIVW'(SCAN_DIV - 1);

    logic [REGFILE_WIDTH-1:0] head;
    logic [REGFILE_WIDTH-1:0] tail;
    logic [DIVW-1:0]          scan_div;
    logic                     push;
    logic                     pop;

    assign full          = (count == COUNT_FULL);
    assign empty         = (count == '0);
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;

    // Gating with rst keeps the write port quiet while reset is held,
    // even though in_ready already reads 1 at that point.
    assign push = bus.in_valid & bus.in_ready & rst;
    assign pop  = bus.out_valid & bus.out_ready;

    assign rf_we        = push;
    assign rf_wa        = tail;
    assign rf_wd        = bus.in_data;
    assign rf_ra0       = head;
    assign bus.out_data = rf_rd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + REGFILE_WIDTH'(1);
            if (pop)  head <= head + REGFILE_WIDTH'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Scanner steps one logical slot every SCAN_DIV cycles, relative to head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_div <= '0;
            scan_idx <= '0;
        end else if (scan_div == DIV_LAST) begin
            scan_div <= '0;
            scan_idx <= scan_idx + REGFILE_WIDTH'(1);
        end else begin
            scan_div <= scan_div + DIVW'(1);
        end
    end

    assign rf_ra1     = head + scan_idx;
    assign scan_valid = ({1'b0, scan_idx} < count);
    assign scan_data  = scan_valid ? rf_rd1 : '0;
endmodule

// File: tb/tb_rf_fifo_ctrl.sv
// Self-checking bench for rf_fifo_ctrl: a behavioural register file plus a
// queue-based reference model of FIFO contents, pointers and scanner position.
module tb_rf_fifo_ctrl;
    localparam int WIDTH = 32;
    localparam int RW    = 5;
    localparam int DEPTH = 32;
    localparam int SDIV  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [RW-1:0]    rf_ra0, rf_ra1, rf_wa;
    logic [WIDTH-1:0] rf_rd0, rf_rd1, rf_wd;
    logic             rf_we;
    logic [RW:0]      count;
    logic             full, empty, scan_valid;
    logic [RW-1:0]    scan_idx;
    logic [WIDTH-1:0] scan_data;

    rf_fifo_ctrl_if #(.WIDTH(WIDTH)) bus ();

    rf_fifo_ctrl #(.WIDTH(WIDTH), .REGFILE_WIDTH(RW), .SCAN_DIV(SDIV)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .rf_ra0(rf_ra0), .rf_rd0(rf_rd0), .rf_ra1(rf_ra1), .rf_rd1(rf_rd1),
        .rf_wa(rf_wa), .rf_we(rf_we), .rf_wd(rf_wd),
        .count(count), .full(full), .empty(empty),
        .scan_idx(scan_idx), .scan_data(scan_data), .scan_valid(scan_valid)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) if (rf_we) mem[rf_wa] <= rf_wd;
    assign rf_rd0 = mem[rf_ra0];
    assign rf_rd1 = mem[rf_ra1];

    // Reference model: logical contents, total pushes/pops and edges since reset.
    logic [WIDTH-1:0] q[$];
    int pushes = 0;
    int pops   = 0;
    int edges  = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) edges <= rst ? edges + 1 : 0;

    task automatic setIn(input bit v, input logic [WIDTH-1:0] d, input bit r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
    endtask

    task automatic tick();
        bit mu, mp;
        logic [WIDTH-1:0] d;
        mu = rst && bus.in_valid && (q.size() < DEPTH);
        mp = rst && bus.out_ready && (q.size() > 0);
        d  = bus.in_data;
        @(posedge clk);
        if (mp) begin void'(q.pop_front()); pops++; end
        if (mu) begin q.push_back(d); pushes++; end
        @(negedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        setIn(0, '0, 0);
        q.delete();
        pushes = 0;
        pops   = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        setIn(1, 32'h55, 1);
        #2;
        checks++; if (count !== 0)        begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0)      begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
        checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (rf_we !== 1'b0)     begin errors++; $display("[TB] FAIL reset_rf_we: got %b expected 0", rf_we); end
        checks++; if (scan_valid !== 1'b0 || scan_data !== '0 || scan_idx !== '0)
            begin errors++; $display("[TB] FAIL reset_scan: got v=%b d=%0h i=%0d expected 0/0/0", scan_valid, scan_data, scan_idx); end
        doReset();
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] vals [3] = '{32'h11, 32'h22, 32'h33};
        doReset();
        for (int i = 0; i < 3; i++) begin
            setIn(1, vals[i], 0);
            #1;
            checks++; if (rf_we !== 1'b1 || rf_wa !== RW'(i))
                begin errors++; $display("[TB] FAIL basic_write%0d: got we=%b wa=%0d expected we=1 wa=%0d", i, rf_we, rf_wa, i); end
            tick();
        end
        setIn(0, '0, 0);
        #1;
        checks++; if (count !== 3) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 3", count); end
        checks++; if (bus.out_data !== 32'h11 || empty !== 1'b0)
            begin errors++; $display("[TB] FAIL basic_head: got %0h empty=%b expected 11 empty=0", bus.out_data, empty); end
        for (int i = 0; i < 3; i++) begin
            setIn(0, '0, 1);
            #1;
            checks++; if (bus.out_data !== vals[i])
                begin errors++; $display("[TB] FAIL basic_pop%0d: got %0h expected %0h", i, bus.out_data, vals[i]); end
            tick();
        end
        setIn(0, '0, 0);
        #1;
        checks++; if (count !== 0 || empty !== 1'b1 || bus.out_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL basic_drained: got count=%0d empty=%b ov=%b expected 0/1/0", count, empty, bus.out_valid); end
    endtask

    task automatic test_full();
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            setIn(1, 32'h100 + i, 0);
            tick();
        end
        setIn(1, 32'hDEAD, 0);
        #1;
        checks++; if (full !== 1'b1 || bus.in_ready !== 1'b0)
            begin errors++; $display("[TB] FAIL full_flags: got full=%b ir=%b expected 1/0", full, bus.in_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL full_no_write: got %b expected 0", rf_we); end
        tick();
        checks++; if (count !== DEPTH) begin errors++; $display("[TB] FAIL full_count: got %0d expected 32", count); end
        for (int i = 0; i < DEPTH; i++) begin
            setIn(0, '0, 1);
            #1;
            checks++; if (bus.out_data !== 32'h100 + i)
                begin errors++; $display("[TB] FAIL full_pop%0d: got %0h expected %0h", i, bus.out_data, 32'h100 + i); end
            tick();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL full_drained: got %b expected 1", empty); end
    endtask

    task automatic test_wrap();
        int wrapExp [5] = '{30, 31, 0, 1, 2};
        logic [WIDTH-1:0] d;
        doReset();
        for (int i = 0; i < 30; i++) begin setIn(1, $urandom, 0); tick(); end
        for (int i = 0; i < 30; i++) begin setIn(0, '0, 1); tick(); end
        for (int i = 0; i < 5; i++) begin
            setIn(1, 32'hC00 + i, 0);
            #1;
            checks++; if (rf_wa !== RW'(wrapExp[i]) || rf_we !== 1'b1)
                begin errors++; $display("[TB] FAIL wrap_wa%0d: got %0d we=%b expected %0d", i, rf_wa, rf_we, wrapExp[i]); end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            setIn(0, '0, 1);
            #1;
            d = q[0];
            checks++; if (bus.out_data !== d)
                begin errors++; $display("[TB] FAIL wrap_pop%0d: got %0h expected %0h", i, bus.out_data, d); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        setIn(1, 32'hA, 0);
        tick();
        setIn(1, 32'hB, 1);
        #1;
        checks++; if (bus.out_data !== 32'hA) begin errors++; $display("[TB] FAIL b2b_old_head: got %0h expected a", bus.out_data); end
        tick();
        setIn(0, '0, 0);
        #1;
        checks++; if (count !== 1 || bus.out_data !== 32'hB)
            begin errors++; $display("[TB] FAIL b2b_after: got count=%0d data=%0h expected 1/b", count, bus.out_data); end
        for (int i = 0; i < DEPTH - 1; i++) begin setIn(1, $urandom, 0); tick(); end
        setIn(1, 32'hBEEF, 1);
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full_write: got %b expected 0", rf_we); end
        tick();
        setIn(0, '0, 0);
        #1;
        checks++; if (count !== DEPTH - 1) begin errors++; $display("[TB] FAIL b2b_full_count: got %0d expected 31", count); end
    endtask

    task automatic test_scanner();
        int expIdx;
        bit expValid;
        logic [WIDTH-1:0] expData;
        doReset();
        setIn(1, 32'h5A5A0001, 0); tick();
        setIn(1, 32'h5A5A0002, 0); tick();
        setIn(0, '0, 0);
        for (int c = 0; c < 40; c++) begin
            expIdx   = (edges / SDIV) % DEPTH;
            expValid = expIdx < q.size();
            expData  = expValid ? q[expIdx] : '0;
            checks++; if (scan_idx !== RW'(expIdx) || scan_valid !== expValid || scan_data !== expData)
                begin errors++; $display("[TB] FAIL scan_c%0d: got i=%0d v=%b d=%0h expected i=%0d v=%b d=%0h",
                                         c, scan_idx, scan_valid, scan_data, expIdx, expValid, expData); end
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (scan_idx !== '0 || count !== 0 || scan_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL scan_async_reset: got i=%0d count=%0d v=%b expected 0/0/0", scan_idx, count, scan_valid); end
        doReset();
    endtask

    task automatic test_random();
        int pPush, expIdx;
        bit expPush, expValid;
        logic [WIDTH-1:0] expData;
        doReset();
        for (int i = 0; i < 400; i++) begin
            pPush = ((i / 50) % 2 == 0) ? 80 : 25;
            setIn($urandom_range(0, 99) < pPush, $urandom, $urandom_range(0, 99) < (100 - pPush));
            #1;
            expPush  = bus.in_valid && q.size() < DEPTH;
            expIdx   = (edges / SDIV) % DEPTH;
            expValid = expIdx < q.size();
            expData  = expValid ? q[expIdx] : '0;
            checks++; if (count !== q.size() || count > DEPTH)
                begin errors++; $display("[TB] FAIL rnd_count%0d: got %0d expected %0d", i, count, q.size()); end
            checks++; if (rf_we !== expPush || (expPush && rf_wa !== RW'(pushes % DEPTH)))
                begin errors++; $display("[TB] FAIL rnd_write%0d: got we=%b wa=%0d expected we=%b wa=%0d", i, rf_we, rf_wa, expPush, pushes % DEPTH); end
            checks++; if (bus.out_valid !== (q.size() > 0) || bus.in_ready !== (q.size() < DEPTH))
                begin errors++; $display("[TB] FAIL rnd_flags%0d: got ov=%b ir=%b for size %0d", i, bus.out_valid, bus.in_ready, q.size()); end
            if (q.size() > 0) begin
                checks++; if (bus.out_data !== q[0] || rf_ra0 !== RW'(pops % DEPTH))
                    begin errors++; $display("[TB] FAIL rnd_head%0d: got %0h@%0d expected %0h@%0d", i, bus.out_data, rf_ra0, q[0], pops % DEPTH); end
            end
            checks++; if (scan_idx !== RW'(expIdx) || scan_valid !== expValid || scan_data !== expData)
                begin errors++; $display("[TB] FAIL rnd_scan%0d: got i=%0d v=%b d=%0h expected i=%0d v=%b d=%0h",
                                         i, scan_idx, scan_valid, scan_data, expIdx, expValid, expData); end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        setIn(0, '0, 0);
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_back_to_back();
        test_scanner();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
